sprite_loader: RTL

Writer side of the sprite pixel memories read by the color mapper. Accepts a byte stream over a valid/ready handshake, packs R,G,B bytes into 24-bit pixels, and stores complete 40x40 note sprites for the five lanes (red, blue, green, yellow, orange). It also provides the synchronous read port the color mapper samples, so sprite art can be reloaded at run time instead of being fixed at synthesis.

---
 rtl/sprite_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sprite_loader.sv
// Byte-stream writer for the five 40x40 lane sprites, plus the registered read port the color mapper samples.
// Pixel writes commit on the edge that accepts the B byte. Reads take one cycle. in_ready drops only in DONE/ERR and during reset.
module sprite_loader #(
  parameter int          SPRITE_W    = 40,
  parameter int          SPRITE_H    = 40,
  parameter int          NUM_SPRITES = 5,
  parameter int          ADDR_W      = 13,
  parameter logic [23:0] KEY_COLOR   = 24'hffaec9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        rd_sel,
  input  logic [ADDR_W-1:0] read_address,
  output logic [23:0]       data_Out,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int NPIX       = SPRITE_W * SPRITE_H;
  localparam int DISC_BYTES = 3 * NPIX;
  localparam int MEM_DEPTH  = NUM_SPRITES * NPIX;
  localparam int MEM_AW     = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, PIX, DISCARD, DONE, ERR} state_t;

  state_t            state;
  logic [2:0]        id;
  logic [1:0]        phase;
  logic [ADDR_W-1:0] pix_cnt;
  logic [13:0]       disc_cnt;
  logic [7:0]        r_byte;
  logic [7:0]        g_byte;

  logic              xfer;
  logic              wr_en;
  logic              rd_ok;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

  logic [23:0] mem [0:MEM_DEPTH-1];

  assign xfer   = in_valid && in_ready;
  assign wr_en  = xfer && (state == PIX) && (phase == 2'd2);
  assign wr_idx = MEM_AW'(id) * MEM_AW'(NPIX) + MEM_AW'(pix_cnt);
  assign rd_idx = MEM_AW'(rd_sel) * MEM_AW'(NPIX) + MEM_AW'(read_address);
  assign rd_ok  = (rd_sel < 3'(NUM_SPRITES)) && (read_address < ADDR_W'(NPIX));

  // Sprite storage survives reset, so a load interrupted by reset leaves a partial image.
  always_ff @(posedge Clk) begin
    if (wr_en)
      mem[wr_idx] <= {r_byte, g_byte, in_data};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      data_Out <= KEY_COLOR;
    else if (rd_ok)
      data_Out <= mem[rd_idx];
    else
      data_Out <= KEY_COLOR;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      id         <= '0;
      phase      <= '0;
      pix_cnt    <= '0;
      disc_cnt   <= '0;
      r_byte     <= '0;
      g_byte     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            busy <= 1'b1;
            if (in_data < 8'(NUM_SPRITES)) begin
              id      <= in_data[2:0];
              pix_cnt <= '0;
              phase   <= '0;
              state   <= PIX;
            end else begin
              disc_cnt <= '0;
              state    <= DISCARD;
            end
          end
        end
        PIX: begin
          if (xfer) begin
            case (phase)
              2'd0: begin
                r_byte <= in_data;
                phase  <= 2'd1;
              end
              2'd1: begin
                g_byte <= in_data;
                phase  <= 2'd2;
              end
              default: begin
                phase <= 2'd0;
                if (pix_cnt == ADDR_W'(NPIX - 1)) begin
                  state     <= DONE;
                  in_ready  <= 1'b0;
                  load_done <= 1'b1;
                end else begin
                  pix_cnt <= pix_cnt + 1'b1;
                end
              end
            endcase
          end
        end
        DISCARD: begin
          if (xfer) begin
            if (disc_cnt == 14'(DISC_BYTES - 1)) begin
              state      <= ERR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else begin
              disc_cnt <= disc_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          load_done <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        ERR: begin
          load_error <= 1'b0;
          busy       <= 1'b0;
          in_ready   <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
